data_plane_link_tx: RTL and testbench
=====================================

# data_plane_link_tx

Downstream stage of `data_plane_tx`: buffers the 32-bit packets it produces, frames each one as preamble + data beats + check beat, and streams the frame to the photonic link transmitter over a valid/ready lane. It returns `data_tx_flag_out` to `data_plane_tx` as a one-cycle "packet launched" pulse per completed frame.

## Interface
- `DEPTH`, 4: packet FIFO depth in entries; power of two, ≥2.
- `LANE_W`, 8: link lane width in bits; legal values are 8, 16 and 32.
- `PREAMBLE`, 8'hA5: start-of-frame word, zero-extended to `LANE_W`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `tx_flag`  in  1  packet-valid strobe from `data_plane_tx`; one packet is offered per cycle it is high.
- `data_tx_packet`  in  32  packet word, sampled when `tx_flag`=1.
- `link_ready`  in  1  link transmitter accepts the current beat.
- `link_valid`  out  1  beat on `link_data` is valid.
- `link_data`  out  LANE_W  current beat.
- `link_sof`  out  1  high on the preamble beat only.
- `data_tx_flag_out`  out  1  one-cycle pulse per completed frame, fed back to `data_plane_tx`.
- `fifo_count`  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the frame in flight.
- `fifo_full`  out  1  `fifo_count`==DEPTH.
- `overflow`  out  1  sticky; set when a packet is dropped.

## Operation
- FIFO:
  - A write occurs when `tx_flag`=1 and either `fifo_count`<DEPTH or a pop occurs in the same cycle.
  - Otherwise the packet is dropped and `overflow` is set. `overflow` is cleared only by reset.
- Frame format:
  - `NB` = 32/LANE_W data beats, sent MSB-first.
  - Frame = PRE beat, then `NB` DATA beats, then one CHK beat: `NB`+2 beats in total.
  - CHK = XOR of all `NB` data beats.
- A beat completes on any edge where `link_valid`=1 and `link_ready`=1.
  - While `link_ready`=0, `link_data`, `link_sof` and `link_valid` hold.
  - `link_valid` never drops mid-frame.
- FSM states and transitions:
  - IDLE: `link_valid`=0, `link_data`=0. If `fifo_count`>0, pop the head into the frame register, clear the beat counter and go to PRE.
  - PRE: drive `PREAMBLE` with `link_sof`=1. On completion go to DATA.
  - DATA: drive the slice selected by the beat counter. On each completion increment the counter and accumulate the XOR. After the `NB`th completion go to CHK.
  - CHK: drive the accumulated XOR. On completion schedule the `data_tx_flag_out` pulse. Then, if `fifo_count`>0, pop and go directly to PRE with no idle cycle; otherwise go to IDLE.
- The XOR accumulator and beat counter clear on every pop.
- All outputs are registered.

## Timing
- Reset values: `link_valid`=0, `link_data`=0, `link_sof`=0, `data_tx_flag_out`=0, `fifo_count`=0, `fifo_full`=0, `overflow`=0. FSM = IDLE, FIFO empty.
- Reset takes effect asynchronously. Release is synchronous to `clk`.
- Reset mid-frame abandons the frame and empties the FIFO. No `data_tx_flag_out` pulse is produced for the abandoned frame.
- Latency with FSM in IDLE and FIFO empty:
  - `tx_flag` sampled at edge E0 gives `fifo_count`=1 after E0.
  - Pop at E1; PRE is driven from E1.
- Frame length with `link_ready` held high: `NB`+2 cycles.
- `data_tx_flag_out` is high for exactly the one cycle after the CHK beat's completing edge.
- Back-to-back frames are gapless: the next PRE is driven in the same cycle as the flag pulse.
- Write and pop in the same cycle: occupancy is unchanged and `fifo_full` stays asserted if it was asserted.

## Test plan
- Single packet, `LANE_W`=8, `link_ready`=1, `tx_flag` with 32'h0001_000A:
  - Beats A5 (`link_sof`=1), 00, 01, 00, 0A, 0B on consecutive cycles, starting 1 cycle after the write edge.
  - `data_tx_flag_out` pulses in the cycle after 0B; `link_valid` then falls.
- Backpressure, same packet, `link_ready`=0 for 3 cycles while beat 01 is driven:
  - 01 holds with `link_valid`=1 for those cycles.
  - Frame completes in 9 cycles; CHK is still 0B.
- Back-to-back: `tx_flag` with 32'h0001_0005, then 32'h0001_0002 on the next cycle:
  - 12 consecutive valid beats with CHK 04 then 03.
  - Two flag pulses, 6 cycles apart.
- Overflow, `DEPTH`=4, `link_ready`=0, 6 consecutive writes:
  - First packet enters PRE; `fifo_full`=1 after write 5; write 6 is dropped and `overflow`=1.
  - After raising `link_ready`: exactly 5 frames, 5 flag pulses, `overflow` stays 1.
- Reset mid-frame: drive `rst`=0 while the third data beat is on the lane:
  - All outputs go to reset values immediately; no flag pulse.
  - After release with no `tx_flag`, `link_valid` stays 0.
- `LANE_W`=16, packet 32'h1234_5678: beats 00A5, 1234, 5678, 444C.

Source files
------------

// File: rtl/data_plane_link_tx.sv
// Link-side framer for data_plane_tx: packet FIFO plus PRE/DATA/CHK beat
// sequencer on a valid/ready lane, with a per-frame launch pulse back.
module data_plane_link_tx #(
  parameter int         DEPTH    = 4,
  parameter int         LANE_W   = 8,
  parameter logic [7:0] PREAMBLE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_flag,
  input  logic [31:0]              data_tx_packet,
  input  logic                     link_ready,
  output logic                     link_valid,
  output logic [LANE_W-1:0]        link_data,
  output logic                     link_sof,
  output logic                     data_tx_flag_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     overflow
);

  localparam int NB   = 32 / LANE_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(NB + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_CHK
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        frame_q, frame_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [LANE_W-1:0]  acc_q, acc_d;
  logic               valid_q, valid_d;
  logic [LANE_W-1:0]  data_q, data_d;
  logic               sof_q, sof_d;
  logic               flag_q, flag_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic               ovf_q, ovf_d;
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [31:0]        mem_q [DEPTH];

  logic done;
  logic pop;
  logic wr_en;

  function automatic logic [LANE_W-1:0] slice(
    input logic [31:0] w,
    input int          i
  );
    logic [31:0] s;
    s = w << (i * LANE_W);
    return s[31 -: LANE_W];
  endfunction

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    flag_d  = 1'b0;
    ovf_d   = ovf_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    pop     = 1'b0;
    done    = valid_q & link_ready;

    case (state_q)
      S_IDLE: pop = (count_q != '0);
      S_PRE: begin
        if (done) begin
          state_d = S_DATA;
          data_d  = slice(frame_q, 0);
          sof_d   = 1'b0;
        end
      end
      S_DATA: begin
        if (done) begin
          acc_d = acc_q ^ data_q;
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == LAST) begin
            state_d = S_CHK;
            data_d  = acc_q ^ data_q;
          end else begin
            data_d = slice(frame_q, int'(cnt_q) + 1);
          end
        end
      end
      S_CHK: begin
        if (done) begin
          flag_d = 1'b1;
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            sof_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop always launches straight into PRE, even from CHK.
    if (pop) begin
      frame_d = mem_q[rd_q];
      cnt_d   = '0;
      acc_d   = '0;
      state_d = S_PRE;
      valid_d = 1'b1;
      data_d  = LANE_W'(PREAMBLE);
      sof_d   = 1'b1;
      rd_d    = rd_q + AW'(1);
    end

    wr_en = tx_flag & ((count_q != CW'(DEPTH)) | pop);
    if (wr_en) wr_d = wr_q + AW'(1);
    if (tx_flag && !wr_en) ovf_d = 1'b1;

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      flag_q  <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (wr_en) mem_q[wr_q] <= data_tx_packet;
    end
  end

  assign link_valid       = valid_q;
  assign link_data        = data_q;
  assign link_sof         = sof_q;
  assign data_tx_flag_out = flag_q;
  assign fifo_count       = count_q;
  assign fifo_full        = full_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_data_plane_link_tx.sv
// Scoreboard bench for data_plane_link_tx: queue-level reference model,
// beat scoreboard on the lane, plus a 16-bit lane instance.
module tb_data_plane_link_tx;

  localparam int DEPTH = 4;
  localparam int LW    = 8;
  localparam int NB    = 32 / LW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_flag = 1'b0;
  logic [31:0] pkt = '0;
  logic        link_ready = 1'b1;
  logic        link_valid;
  logic [7:0]  link_data;
  logic        link_sof;
  logic        flag_out;
  logic [2:0]  fifo_count;
  logic        fifo_full;
  logic        overflow;

  logic        tx16 = 1'b0;
  logic [31:0] pkt16 = '0;
  logic        v16;
  logic [15:0] d16;
  logic        sof16;
  logic        flag16;
  logic [2:0]  cnt16;
  logic        full16;
  logic        ovf16;

  int checks = 0;
  int failures = 0;
  int flag16_seen = 0;

  always #5 clk = ~clk;

  data_plane_link_tx #(.DEPTH(DEPTH), .LANE_W(LW), .PREAMBLE(8'hA5)) dut (
    .clk(clk), .rst(rst), .tx_flag(tx_flag), .data_tx_packet(pkt),
    .link_ready(link_ready), .link_valid(link_valid), .link_data(link_data),
    .link_sof(link_sof), .data_tx_flag_out(flag_out),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow)
  );

  data_plane_link_tx #(.DEPTH(4), .LANE_W(16), .PREAMBLE(8'hA5)) dut16 (
    .clk(clk), .rst(rst), .tx_flag(tx16), .data_tx_packet(pkt16),
    .link_ready(1'b1), .link_valid(v16), .link_data(d16),
    .link_sof(sof16), .data_tx_flag_out(flag16),
    .fifo_count(cnt16), .fifo_full(full16), .overflow(ovf16)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packets waiting, frame in progress, expected beats.
  logic [31:0] m_q[$];
  logic [8:0]  exp_q[$];
  logic [16:0] exp16[$];
  bit m_busy = 0;
  int m_idx = 0;
  bit m_ovf = 0;
  bit m_flag = 0;
  bit m_done, m_fin, m_pop, m_acc;

  function automatic void push_frame(input logic [31:0] p);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back({1'b1, 8'hA5});
    for (int i = 0; i < NB; i++) begin
      b = 8'((p >> (24 - 8 * i)) & 32'hFF);
      x = x ^ b;
      exp_q.push_back({1'b0, b});
    end
    exp_q.push_back({1'b0, x});
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_q.delete();
        exp_q.delete();
        m_busy = 0;
        m_idx = 0;
        m_ovf = 0;
        m_flag = 0;
      end else begin
        m_done = m_busy && link_ready;
        m_fin = m_done && (m_idx == NB + 1);
        m_flag = m_fin;
        m_pop = (!m_busy || m_fin) && (m_q.size() > 0);
        m_acc = tx_flag && ((m_q.size() < DEPTH) || m_pop);
        if (m_done) m_idx++;
        if (m_fin) m_busy = 0;
        if (m_pop) begin
          void'(m_q.pop_front());
          m_busy = 1;
          m_idx = 0;
        end
        if (m_acc) begin
          m_q.push_back(pkt);
          push_frame(pkt);
        end else if (tx_flag) begin
          m_ovf = 1;
        end
      end
    end
  end

  // Monitor: compares lane and status against the model every cycle.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      chk("link_valid", 32'(link_valid), 32'(m_busy));
      chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("flag_out", 32'(flag_out), 32'(m_flag));
      if (link_valid) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 32'(link_data), 32'h1FF);
        end else begin
          e = exp_q[0];
          chk("beat_data", 32'(link_data), 32'(e[7:0]));
          chk("beat_sof", 32'(link_sof), 32'(e[8]));
          if (link_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_data", 32'(link_data), 32'h0);
        chk("idle_sof", 32'(link_sof), 32'h0);
      end
    end
  end

  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (flag16) flag16_seen++;
      if (v16) begin
        if (exp16.size() == 0) begin
          chk("beat16_unexpected", 32'(d16), 32'h1FFFF);
        end else begin
          e = exp16.pop_front();
          chk("beat16_data", 32'(d16), 32'(e[15:0]));
          chk("beat16_sof", 32'(sof16), 32'(e[16]));
        end
      end
    end
  end

  task automatic step(input logic tx, input logic [31:0] p, input logic rdy);
    tx_flag = tx;
    pkt = p;
    link_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(link_valid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    rst = 1'b1;
    idle(2, 1'b1);

    // Single packet on both lane widths.
    tx16 = 1'b1;
    pkt16 = 32'h1234_5678;
    exp16.push_back({1'b1, 16'h00A5});
    exp16.push_back({1'b0, 16'h1234});
    exp16.push_back({1'b0, 16'h5678});
    exp16.push_back({1'b0, 16'h444C});
    step(1'b1, 32'h0001_000A, 1'b1);
    tx16 = 1'b0;
    pkt16 = '0;
    idle(8, 1'b1);

    // Backpressure while beat 01 is on the lane.
    step(1'b1, 32'h0001_000A, 1'b1);
    idle(3, 1'b1);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Back-to-back frames.
    step(1'b1, 32'h0001_0005, 1'b1);
    step(1'b1, 32'h0001_0002, 1'b1);
    idle(16, 1'b1);

    // Overflow under stalled link.
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0);
    idle(3, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    idle(40, 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Reset while the third data beat is driven.
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    idle(4, 1'b1);
    chk("pre_rst_beat", 32'(link_data), 32'hBE);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(link_valid), 32'h0);
    chk("arst_data", 32'(link_data), 32'h0);
    chk("arst_sof", 32'(link_sof), 32'h0);
    chk("arst_flag", 32'(flag_out), 32'h0);
    chk("arst_ovf", 32'(overflow), 32'h0);
    chk("arst_count", 32'(fifo_count), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(8, 1'b1);

    // Randomized traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) == 0), $urandom,
           1'($urandom_range(0, 3) != 0));

    // Bounded drain.
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !m_busy && m_q.size() == 0) break;
      step(1'b0, 32'h0, 1'b1);
    end
    idle(2, 1'b1);
    chk("drained", 32'(exp_q.size()), 32'h0);
    chk("lane16_drained", 32'(exp16.size()), 32'h0);
    chk("lane16_flags", 32'(flag16_seen), 32'h1);
    chk("lane16_idle", 32'({ovf16, full16, cnt16}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
